// File: rtl/pipelined_select_mux_pkg.sv
// Shared sizing helpers for the pipelined select mux.
// Both the RTL and the bench use these to derive stage counts and widths.
package pipelined_select_mux_pkg;

    // Ceiling log2; returns 0 for a value of 1.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Number of registered stages needed to resolve sel_w bits, stage_bits at a time.
    function automatic int num_stages(input int sel_w, input int stage_bits);
        return (sel_w + stage_bits - 1) / stage_bits;
    endfunction

    // Select bits consumed by stage s; the last stage may use fewer than stage_bits.
    function automatic int bits_at_stage(input int sel_w, input int stage_bits, input int s);
        int left;
        left = sel_w - s * stage_bits;
        return (left < stage_bits) ? left : stage_bits;
    endfunction

    // Candidate words held by stage s (s = -1 gives the raw input count).
    function automatic int cand_count(input int inputs, input int sel_w,
                                      input int stage_bits, input int s);
        int resolved;
        resolved = (s + 1) * stage_bits;
        if (resolved > sel_w) begin
            resolved = sel_w;
        end
        return inputs >> resolved;
    endfunction

endpackage

// File: rtl/select_mux_stage.sv
// One registered reduction stage: picks one word from every block of
// 2^BITS candidates using the low select bits, and forwards the rest of
// the select alongside the surviving candidates.
module select_mux_stage #(
    parameter int WIDTH    = 32,
    parameter int IN_WORDS = 64,
    parameter int BITS     = 5,
    parameter int SEL_IN   = 6
) (
    input  logic                                               clock,
    input  logic                                               reset_n,
    input  logic                                               up_valid,
    output logic                                               up_ready,
    input  logic [IN_WORDS*WIDTH-1:0]                          up_data,
    input  logic [SEL_IN-1:0]                                  up_sel,
    input  logic                                               dn_ready,
    output logic                                               dn_valid,
    output logic [(IN_WORDS>>BITS)*WIDTH-1:0]                  dn_data,
    output logic [((SEL_IN > BITS) ? SEL_IN - BITS : 1)-1:0]   dn_sel
);

    localparam int OUT_WORDS = IN_WORDS >> BITS;
    localparam int GROUP     = 1 << BITS;
    localparam int SEL_OUT_W = (SEL_IN > BITS) ? SEL_IN - BITS : 1;

    logic [OUT_WORDS*WIDTH-1:0] reduced;
    logic [SEL_OUT_W-1:0]       sel_rest;
    logic [BITS-1:0]            pick;

    assign pick = up_sel[BITS-1:0];

    // An empty stage always accepts, so bubbles collapse while downstream stalls.
    assign up_ready = !dn_valid || dn_ready;

    // Keep the unresolved upper select bits; the final stage has none left.
    if (SEL_IN > BITS) begin : g_rest
        assign sel_rest = up_sel[SEL_IN-1:BITS];
    end else begin : g_none
        assign sel_rest = '0;
    end

    // Reduce each block of GROUP consecutive candidates to the one chosen by pick.
    always_comb begin
        reduced = '0;
        for (int j = 0; j < OUT_WORDS; j++) begin
            reduced[j*WIDTH +: WIDTH] = up_data[(j * GROUP + int'(pick)) * WIDTH +: WIDTH];
        end
    end

    // Stage register: loads (word or bubble) whenever this stage can accept, else holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_sel   <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            dn_data  <= reduced;
            dn_sel   <= sel_rest;
        end
    end

endmodule

// File: rtl/pipelined_select_mux.sv
// Pipelined N:1 word multiplexer with valid/ready handshake. Resolves
// STAGE_BITS select bits per registered stage, low bits first.
module pipelined_select_mux
    import pipelined_select_mux_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INPUTS     = 64,
    parameter int STAGE_BITS = 5,
    localparam int SEL_W     = clog2(INPUTS)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_select,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int NUM_STAGES = num_stages(SEL_W, STAGE_BITS);

    logic [NUM_STAGES:0]   vld;
    logic [NUM_STAGES:1]   rdy;
    logic [NUM_STAGES-1:0] stage_ready;
    logic                  unused_ready;

    assign vld[0]    = in_valid;
    assign out_valid = vld[NUM_STAGES];
    assign in_ready  = stage_ready[0];

    // Inner stages' ready outputs equal rdy[] below; only stage 0's leaves the block.
    assign unused_ready = ^stage_ready;

    // Downstream-ready per stage, derived from registered valids so the only
    // combinational path is out_ready -> in_ready.
    always_comb begin
        rdy = '0;
        rdy[NUM_STAGES] = out_ready;
        for (int s = NUM_STAGES - 1; s >= 1; s--) begin
            rdy[s] = rdy[s + 1] || !vld[s + 1];
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_st
        localparam int IN_WORDS  = cand_count(INPUTS, SEL_W, STAGE_BITS, s - 1);
        localparam int BITS      = bits_at_stage(SEL_W, STAGE_BITS, s);
        localparam int SEL_IN    = SEL_W - s * STAGE_BITS;
        localparam int SEL_OUT_W = (SEL_IN > BITS) ? SEL_IN - BITS : 1;

        logic [IN_WORDS*WIDTH-1:0]          idat;
        logic [SEL_IN-1:0]                  isel;
        logic [(IN_WORDS>>BITS)*WIDTH-1:0]  odat;
        logic [SEL_OUT_W-1:0]               osel;

        if (s == 0) begin : g_head
            assign idat = in_data;
            assign isel = in_select;
        end else begin : g_body
            assign idat = g_st[s-1].odat;
            assign isel = g_st[s-1].osel;
        end

        // All select bits are consumed by the last stage; its padding bit is dead.
        if (s == NUM_STAGES - 1) begin : g_tail
            logic unused_sel;
            assign unused_sel = ^osel;
        end

        select_mux_stage #(
            .WIDTH    (WIDTH),
            .IN_WORDS (IN_WORDS),
            .BITS     (BITS),
            .SEL_IN   (SEL_IN)
        ) u_stage (
            .clock    (clock),
            .reset_n  (reset_n),
            .up_valid (vld[s]),
            .up_ready (stage_ready[s]),
            .up_data  (idat),
            .up_sel   (isel),
            .dn_ready (rdy[s+1]),
            .dn_valid (vld[s+1]),
            .dn_data  (odat),
            .dn_sel   (osel)
        );
    end

    assign out_data = g_st[NUM_STAGES-1].odat;

endmodule
